sbox_cfg: RTL and testbench

- Parametrised FPGA routing switch box, the successor to the fixed 5x4 matrix.
- Has N_TB pins each on top and bottom and N_LR pins each on left and right.
- Every pin's output is driven from any pin's input, or left undriven, according to a per-pin route word.
- Route words load through a handshaked write port into a shadow bank and are applied atomically on commit. Active routing can be read back.
- Sits in each routing tile between logic-block pins and neighbouring switch boxes.

---
 rtl/sbox_pkg.sv | 36 +++
 rtl/sbox_route_mux.sv | 38 +++
 rtl/sbox_cfg.sv | 124 ++++++++++++
 tb/tb_sbox_cfg.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// Shared definitions for the parametrised switch box: route-word side codes,
// controller states and side geometry helpers.
package sbox_pkg;

  localparam logic [2:0] SIDE_OFF    = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  // Pins are numbered clockwise: top, right, bottom, left.
  function automatic int side_base(input logic [2:0] side, input int n_tb, input int n_lr);
    case (side)
      SIDE_TOP:    side_base = 0;
      SIDE_RIGHT:  side_base = n_tb;
      SIDE_BOTTOM: side_base = n_tb + n_lr;
      SIDE_LEFT:   side_base = 2 * n_tb + n_lr;
      default:     side_base = 0;
    endcase
  endfunction

  // Off and reserved codes have size 0, so any index on them selects nothing.
  function automatic int side_size(input logic [2:0] side, input int n_tb, input int n_lr);
    case (side)
      SIDE_TOP, SIDE_BOTTOM: side_size = n_tb;
      SIDE_RIGHT, SIDE_LEFT: side_size = n_lr;
      default:               side_size = 0;
    endcase
  endfunction

endpackage

// File: rtl/sbox_route_mux.sv
// Per-pin source selector: decodes one active route word into a driven value
// and output enable. Reserved or out-of-range words decode as off.
module sbox_route_mux
  import sbox_pkg::*;
#(
  parameter int N_TB   = 5,
  parameter int N_LR   = 4,
  parameter int N_PINS = 18,
  parameter int CFG_W  = 6
) (
  input  logic [CFG_W-1:0]  route,
  input  logic [N_PINS-1:0] pin_in,
  output logic              out,
  output logic              oe
);

  logic [2:0]       side;
  logic [CFG_W-4:0] idx;
  int               src;

  assign side = route[2:0];
  assign idx  = route[CFG_W-1:3];

  always_comb begin
    out = 1'b0;
    oe  = 1'b0;
    src = -1;
    if (int'(idx) < side_size(side, N_TB, N_LR))
      src = side_base(side, N_TB, N_LR) + int'(idx);
    for (int p = 0; p < N_PINS; p++) begin
      if (p == src) begin
        out = pin_in[p];
        oe  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sbox_cfg.sv
// Switch box top: shadow/active route banks, commit controller, write checks,
// readback and optional output register.  state | meaning:
// ST_IDLE accepts writes and commit requests | ST_COMMIT copies shadow to active.
module sbox_cfg
  import sbox_pkg::*;
#(
  parameter int  N_TB    = 5,
  parameter int  N_LR    = 4,
  parameter int  REG_OUT = 0,
  localparam int N_PINS  = 2 * N_TB + 2 * N_LR,
  localparam int MAX_SD  = (N_TB > N_LR) ? N_TB : N_LR,
  localparam int IDX_W   = (MAX_SD > 1) ? $clog2(MAX_SD) : 1,
  localparam int CFG_W   = IDX_W + 3,
  localparam int ADDR_W  = $clog2(N_PINS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_PINS-1:0] pin_in,
  output logic [N_PINS-1:0] pin_out,
  output logic [N_PINS-1:0] pin_oe,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CFG_W-1:0]  rd_data
);

  logic [CFG_W-1:0]  shadow [N_PINS];
  logic [CFG_W-1:0]  active [N_PINS];
  state_t            state;
  logic              wr_fire;
  logic              wr_ok;
  logic [2:0]        wr_side;
  logic [IDX_W-1:0]  wr_idx;
  logic [CFG_W-1:0]  rd_next;
  logic [N_PINS-1:0] mux_out;
  logic [N_PINS-1:0] mux_oe;

  assign cfg_ready = !rst && (state == ST_IDLE);
  assign wr_fire   = cfg_valid && cfg_ready;
  assign wr_side   = cfg_data[2:0];
  assign wr_idx    = cfg_data[CFG_W-1:3];

  always_comb begin
    wr_ok = int'(cfg_addr) < N_PINS;
    if (side_size(wr_side, N_TB, N_LR) != 0) begin
      if (int'(wr_idx) >= side_size(wr_side, N_TB, N_LR))
        wr_ok = 1'b0;
      else if (side_base(wr_side, N_TB, N_LR) + int'(wr_idx) == int'(cfg_addr))
        wr_ok = 1'b0;
    end
  end

  always_comb begin
    rd_next = '0;
    for (int p = 0; p < N_PINS; p++)
      if (p == int'(rd_addr)) rd_next = active[p];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      rd_data  <= '0;
      for (int p = 0; p < N_PINS; p++) begin
        shadow[p] <= '0;
        active[p] <= '0;
      end
    end else begin
      cfg_done <= 1'b0;
      rd_data  <= rd_next;
      if (wr_fire && !wr_ok) cfg_err <= 1'b1;
      for (int p = 0; p < N_PINS; p++)
        if (wr_fire && wr_ok && p == int'(cfg_addr)) shadow[p] <= cfg_data;
      case (state)
        ST_IDLE: begin
          if (cfg_commit) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // Whole-bank copy in one edge keeps old/new routing from mixing.
          for (int p = 0; p < N_PINS; p++) active[p] <= shadow[p];
          cfg_done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_PINS; g++) begin : g_mux
    sbox_route_mux #(
      .N_TB  (N_TB),
      .N_LR  (N_LR),
      .N_PINS(N_PINS),
      .CFG_W (CFG_W)
    ) u_mux (
      .route (active[g]),
      .pin_in(pin_in),
      .out   (mux_out[g]),
      .oe    (mux_oe[g])
    );
  end

  if (REG_OUT != 0) begin : g_reg_out
    always_ff @(posedge clk) begin
      if (rst) begin
        pin_out <= '0;
        pin_oe  <= '0;
      end else begin
        pin_out <= mux_out;
        pin_oe  <= mux_oe;
      end
    end
  end else begin : g_comb_out
    assign pin_out = mux_out;
    assign pin_oe  = mux_oe;
  end

endmodule

// File: tb/tb_sbox_cfg.sv
// Scoreboard bench for sbox_cfg: a combinational and a registered-output
// instance share stimulus and are checked against a route-table model.
module tb_sbox_cfg;

  localparam int NP = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pin_in;
  logic [NP-1:0] out0, oe0, out1, oe1;
  logic          cfg_valid, cfg_commit;
  logic [4:0]    cfg_addr, rd_addr;
  logic [5:0]    cfg_data;
  logic          rdy0, rdy1, done0, done1, err0, err1;
  logic [5:0]    rd0, rd1;

  always #5 clk = ~clk;

  sbox_cfg #(.N_TB(5), .N_LR(4), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .pin_in(pin_in), .pin_out(out0), .pin_oe(oe0),
    .cfg_valid(cfg_valid), .cfg_ready(rdy0), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_done(done0), .cfg_err(err0),
    .rd_addr(rd_addr), .rd_data(rd0));

  sbox_cfg #(.N_TB(5), .N_LR(4), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .pin_in(pin_in), .pin_out(out1), .pin_oe(oe1),
    .cfg_valid(cfg_valid), .cfg_ready(rdy1), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_done(done1), .cfg_err(err1),
    .rd_addr(rd_addr), .rd_data(rd1));

  typedef struct {
    logic [NP-1:0] out0, oe0, out1, oe1;
    logic          rdy, done, err;
    logic [5:0]    rd;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Route-table model: side geometry indexed by side code (0 and 5..7 are off).
  int         base_a[8] = '{0, 0, 5, 9, 14, 0, 0, 0};
  int         size_a[8] = '{0, 5, 4, 5, 4, 0, 0, 0};
  logic [5:0] sh_m[NP];
  logic [5:0] ac_m[NP];
  bit         commit_pending;
  bit         done_m, err_m;
  logic [5:0] rd_m;
  logic [NP-1:0] rq_out, rq_oe;
  int         cyc = 0;
  bit         hold_in = 0;

  function automatic int src_of(input logic [5:0] w);
    int s = int'(w) % 8;
    int i = int'(w) / 8;
    if (i < size_a[s]) return base_a[s] + i;
    return -1;
  endfunction

  task automatic route_all(output logic [NP-1:0] o, output logic [NP-1:0] e);
    for (int p = 0; p < NP; p++) begin
      int s = src_of(ac_m[p]);
      o[p] = (s >= 0) ? pin_in[s] : 1'b0;
      e[p] = (s >= 0);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      sh_m[p] = '0;
      ac_m[p] = '0;
    end
    commit_pending = 0;
    done_m = 0;
    err_m  = 0;
    rd_m   = '0;
    rq_out = '0;
    rq_oe  = '0;
  endtask

  // One clock cycle: queue the expected outputs for the inputs now applied,
  // then advance the model across the coming edge.
  task automatic step(output bit accepted);
    exp_t          e;
    logic [NP-1:0] o, en;
    logic [5:0]    nrd;
    bit            rdy;
    int            a, s, i;
    bit            bad;
    if (!hold_in) begin
      pin_in  = NP'($urandom());
      rd_addr = 5'($urandom_range(0, 23));
    end
    route_all(o, en);
    rdy = !rst && !commit_pending;
    e.out0 = o;      e.oe0 = en;
    e.out1 = rq_out; e.oe1 = rq_oe;
    e.rdy = rdy; e.done = done_m; e.err = err_m; e.rd = rd_m; e.cyc = cyc;
    q.push_back(e);
    accepted = rdy && cfg_valid;
    if (rst) begin
      model_reset();
    end else begin
      nrd = (int'(rd_addr) < NP) ? ac_m[rd_addr] : 6'd0;
      done_m = commit_pending;
      if (commit_pending) begin
        for (int p = 0; p < NP; p++) ac_m[p] = sh_m[p];
        commit_pending = 0;
      end else if (cfg_commit) begin
        commit_pending = 1;
      end
      if (accepted) begin
        a = int'(cfg_addr);
        s = int'(cfg_data) % 8;
        i = int'(cfg_data) / 8;
        bad = (a >= NP) || (s >= 1 && s <= 4 && (i >= size_a[s] || base_a[s] + i == a));
        if (bad) err_m = 1;
        else sh_m[a] = cfg_data;
      end
      rd_m   = nrd;
      rq_out = o;
      rq_oe  = en;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  task automatic wr(input int a, input int d);
    bit acc;
    int tries = 0;
    cfg_valid = 1;
    cfg_addr  = 5'(a);
    cfg_data  = 6'(d);
    do begin
      step(acc);
      tries++;
    end while (!acc && tries < 10);
    cfg_valid = 0;
  endtask

  task automatic commit();
    bit acc;
    cfg_commit = 1;
    step(acc);
    cfg_commit = 0;
    idle(3);
  endtask

  function automatic int rw(input int idx, input int side);
    return idx * 8 + side;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp, input int c);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", nm, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pin_out_comb", 32'(out0), 32'(e.out0), e.cyc);
      chk("pin_oe_comb",  32'(oe0),  32'(e.oe0),  e.cyc);
      chk("pin_out_reg",  32'(out1), 32'(e.out1), e.cyc);
      chk("pin_oe_reg",   32'(oe1),  32'(e.oe1),  e.cyc);
      chk("cfg_ready0", 32'(rdy0),  32'(e.rdy),  e.cyc);
      chk("cfg_ready1", 32'(rdy1),  32'(e.rdy),  e.cyc);
      chk("cfg_done0",  32'(done0), 32'(e.done), e.cyc);
      chk("cfg_done1",  32'(done1), 32'(e.done), e.cyc);
      chk("cfg_err0",   32'(err0),  32'(e.err),  e.cyc);
      chk("cfg_err1",   32'(err1),  32'(e.err),  e.cyc);
      chk("rd_data0",   32'(rd0),   32'(e.rd),   e.cyc);
      chk("rd_data1",   32'(rd1),   32'(e.rd),   e.cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bit acc;
    rst = 1; cfg_valid = 0; cfg_commit = 0; cfg_addr = '0; cfg_data = '0;
    rd_addr = '0; pin_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    step(acc);
    rst = 0;
    for (int a = 0; a < 24; a++) begin
      hold_in = 1;
      rd_addr = 5'(a);
      step(acc);
    end
    hold_in = 0;

    // Pin 0 from bottom index 2 (pin 11), then toggle the source.
    wr(0, rw(2, 3));
    idle(2);
    commit();
    hold_in = 1;
    pin_in = '0;           step(acc);
    pin_in = NP'(1 << 11); step(acc);
    pin_in = '0;           step(acc);
    hold_in = 0;

    // Rejected writes: index past side, self-select, address out of range.
    wr(14, rw(4, 2));
    wr(3,  rw(3, 1));
    wr(20, rw(0, 1));
    commit();
    hold_in = 1;
    rd_addr = 5'd14; step(acc); step(acc);
    rd_addr = 5'd3;  step(acc); step(acc);
    hold_in = 0;

    // Atomic swap of two routes.
    wr(5, rw(0, 1));
    wr(6, rw(1, 1));
    commit();
    wr(5, rw(1, 1));
    wr(6, rw(0, 1));
    commit();

    // Write together with commit, then a write held across COMMIT.
    cfg_valid = 1; cfg_addr = 5'd7; cfg_data = 6'(rw(2, 4)); cfg_commit = 1;
    step(acc);
    cfg_commit = 0; cfg_addr = 5'd8; cfg_data = 6'(rw(0, 2));
    step(acc);
    step(acc);
    cfg_valid = 0;
    idle(2);
    commit();

    // Reset landing on the COMMIT cycle.
    wr(2, rw(1, 2));
    cfg_commit = 1; step(acc);
    cfg_commit = 0; rst = 1; step(acc);
    rst = 0;
    idle(4);

    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 149) == 0);
      cfg_valid  = $urandom_range(0, 1) == 1;
      cfg_addr   = 5'($urandom_range(0, 23));
      cfg_data   = 6'(rw($urandom_range(0, 5), $urandom_range(0, 7)));
      cfg_commit = ($urandom_range(0, 7) == 0);
      step(acc);
    end
    rst = 0; cfg_valid = 0; cfg_commit = 0;
    idle(3);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
